// File: rtl/ikaopll_lfo_pkg.sv
// Shared types and default constants for the parametrised OPLL LFO.
package ikaopll_lfo_pkg;

    typedef enum logic {
        AM_UP   = 1'b0,
        AM_DOWN = 1'b1
    } am_state_t;

    localparam int LFO_PRESC_W  = 6;
    localparam int LFO_PM_DIV_W = 4;
    localparam int LFO_PM_W     = 3;
    localparam int LFO_AM_CW    = 7;
    localparam int LFO_AM_PEAK  = 105;
    localparam int LFO_AM_OUT_W = 4;

    localparam int TEST_CLR  = 1;
    localparam int TEST_FAST = 3;

endpackage

// File: rtl/ikaopll_lfo_tri.sv
// Up/down triangle counter for the tremolo path; apex and zero are each held for one step.
module ikaopll_lfo_tri
    import ikaopll_lfo_pkg::*;
#(
    parameter int AM_CW   = LFO_AM_CW,
    parameter int AM_PEAK = LFO_AM_PEAK
)
(
    input  logic             emuclk,
    input  logic             rst,
    input  logic             cen,
    input  logic             advance,
    input  logic             clear,
    output logic [AM_CW-1:0] cnt,
    output logic             dir
);

    localparam logic [AM_CW-1:0] PEAK = AM_CW'(AM_PEAK);

    am_state_t        state;
    am_state_t        state_nx;
    logic [AM_CW-1:0] cnt_nx;

    always_ff @(posedge emuclk or posedge rst) begin
        if (rst) begin
            state <= AM_UP;
            cnt   <= '0;
        end else if (cen) begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Turning at the apex loads peak-1 and turning at zero loads 1, so the period is 2*peak.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (clear) begin
            state_nx = AM_UP;
            cnt_nx   = '0;
        end else if (advance) begin
            case (state)
                AM_UP: begin
                    if (cnt >= PEAK) begin
                        state_nx = AM_DOWN;
                        cnt_nx   = cnt - 1'b1;
                    end else begin
                        cnt_nx   = cnt + 1'b1;
                    end
                end
                AM_DOWN: begin
                    if (cnt == '0) begin
                        state_nx = AM_UP;
                        cnt_nx   = AM_CW'(1);
                    end else begin
                        cnt_nx   = cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        dir = (state == AM_DOWN);
    end

endmodule

// File: rtl/ikaopll_lfo_param.sv
// Parametrised OPLL LFO: frame prescaler, vibrato (PM) counter and latched tremolo (AM) value.
module ikaopll_lfo_param
    import ikaopll_lfo_pkg::*;
#(
    parameter int PRESC_W  = LFO_PRESC_W,
    parameter int PM_DIV_W = LFO_PM_DIV_W,
    parameter int PM_W     = LFO_PM_W,
    parameter int AM_CW    = LFO_AM_CW,
    parameter int AM_PEAK  = LFO_AM_PEAK,
    parameter int AM_OUT_W = LFO_AM_OUT_W
)
(
    input  logic                i_EMUCLK,
    input  logic                i_RST,
    input  logic                i_phi1_NCEN_n,
    input  logic                i_CYCLE_00,
    input  logic                i_CYCLE_21,
    input  logic [3:0]          i_TEST,
    input  logic [1:0]          i_RATE,
    input  logic                i_AM_DEPTH,
    input  logic                i_SYNC,
    output logic [PM_W-1:0]     o_PMVAL,
    output logic [AM_OUT_W-1:0] o_AMVAL,
    output logic                o_AM_DIR
);

    if (AM_PEAK <= 0 || AM_PEAK >= (1 << AM_CW)) begin : g_bad_peak
        $error("AM_PEAK must lie in 1 .. 2^AM_CW-1");
    end
    if (AM_OUT_W < 1 || AM_OUT_W > AM_CW - 2) begin : g_bad_out_w
        $error("AM_OUT_W must lie in 1 .. AM_CW-2");
    end

    logic                cen;
    logic                clr;
    logic                fast;
    logic                tick;
    logic                advance_pm;
    logic                advance_am;
    logic [PRESC_W-1:0]  presc;
    logic [PRESC_W-1:0]  presc_mask;
    logic [PM_DIV_W-1:0] pm_div;
    logic [PM_W-1:0]     pm_cnt;
    logic [AM_CW-1:0]    am_cnt;
    logic [AM_CW-1:0]    am_scaled;
    logic                unused_test;

    assign cen         = ~i_phi1_NCEN_n;
    assign clr         = i_TEST[TEST_CLR] | i_SYNC;
    assign fast        = i_CYCLE_21 & i_TEST[TEST_FAST];
    assign unused_test = ^{i_TEST[0], i_TEST[2]};

    // The rate input shortens the prescaler by masking its top bits; the count itself is never reset.
    assign presc_mask = {PRESC_W{1'b1}} >> i_RATE;
    assign tick       = i_CYCLE_21 & ((presc & presc_mask) == presc_mask);
    assign advance_pm = (tick & (&pm_div)) | fast;
    assign advance_am = tick | fast;

    assign am_scaled = i_AM_DEPTH ? (am_cnt >> (AM_CW - AM_OUT_W + 2))
                                  : (am_cnt >> (AM_CW - AM_OUT_W));

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            presc  <= '0;
            pm_div <= '0;
            pm_cnt <= '0;
        end else if (cen) begin
            if (clr) begin
                presc  <= '0;
                pm_div <= '0;
                pm_cnt <= '0;
            end else begin
                if (i_CYCLE_21) presc  <= presc + 1'b1;
                if (tick)       pm_div <= pm_div + 1'b1;
                if (advance_pm) pm_cnt <= pm_cnt + 1'b1;
            end
        end
    end

    // Clear deliberately leaves the latched tremolo value alone until the next CYCLE_00.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            o_AMVAL <= '0;
        end else if (cen && i_CYCLE_00) begin
            o_AMVAL <= am_scaled[AM_OUT_W-1:0];
        end
    end

    ikaopll_lfo_tri #(
        .AM_CW   (AM_CW),
        .AM_PEAK (AM_PEAK)
    ) u_tri (
        .emuclk  (i_EMUCLK),
        .rst     (i_RST),
        .cen     (cen),
        .advance (advance_am),
        .clear   (clr),
        .cnt     (am_cnt),
        .dir     (o_AM_DIR)
    );

    assign o_PMVAL = pm_cnt;

    always @(posedge i_EMUCLK) begin
        if (!i_RST) begin
            assert (int'(i_RATE) < PRESC_W)
                else $error("i_RATE must be below PRESC_W");
        end
    end

endmodule

// File: tb/tb_ikaopll_lfo_param.sv
// Directed bench for ikaopll_lfo_param with hand-computed expectations at default parameters.
module tb_ikaopll_lfo_param;

    logic       emuclk = 1'b0;
    logic       rst = 1'b1;
    logic       ncen = 1'b0;
    logic       cyc00 = 1'b0;
    logic       cyc21 = 1'b0;
    logic [3:0] test = 4'd0;
    logic [1:0] rate = 2'd0;
    logic       am_depth = 1'b0;
    logic       sync = 1'b0;
    logic [2:0] pmval;
    logic [3:0] amval;
    logic       am_dir;

    int compared = 0;
    int mismatched = 0;

    always #5 emuclk = ~emuclk;

    ikaopll_lfo_param dut (
        .i_EMUCLK      (emuclk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen),
        .i_CYCLE_00    (cyc00),
        .i_CYCLE_21    (cyc21),
        .i_TEST        (test),
        .i_RATE        (rate),
        .i_AM_DEPTH    (am_depth),
        .i_SYNC        (sync),
        .o_PMVAL       (pmval),
        .o_AMVAL       (amval),
        .o_AM_DIR      (am_dir)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // n enabled edges with the given strobes, then strobes drop at the following negedge
    task automatic applyStimulus(input int n, input logic c21, input logic c00);
        for (int i = 0; i < n; i++) begin
            @(negedge emuclk);
            cyc21 = c21;
            cyc00 = c00;
        end
        @(negedge emuclk);
        cyc21 = 1'b0;
        cyc00 = 1'b0;
    endtask

    task automatic doReset();
        @(negedge emuclk);
        rst = 1'b1;
        test = 4'd0;
        rate = 2'd0;
        am_depth = 1'b0;
        sync = 1'b0;
        ncen = 1'b0;
        @(negedge emuclk);
        rst = 1'b0;
    endtask

    initial begin
        doReset();
        checkOutput("reset_pm", pmval, 0);
        checkOutput("reset_am", amval, 0);
        checkOutput("reset_dir", am_dir, 0);

        // Default rate: PM steps every 1024 strobes, AM every 64.
        applyStimulus(1023, 1'b1, 1'b0);
        checkOutput("pm_before_1024", pmval, 0);
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("pm_at_1024", pmval, 1);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("am_16_ticks", amval, 2);
        applyStimulus(8191 - 1024, 1'b1, 1'b0);
        checkOutput("pm_at_8191", pmval, 7);
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("pm_wrap_8192", pmval, 0);
        checkOutput("dir_128_ticks", am_dir, 1);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("am_128_ticks", amval, 10);

        // RATE=2: tick every 16 strobes.
        doReset();
        rate = 2'd2;
        applyStimulus(255, 1'b1, 1'b0);
        checkOutput("rate2_pm_255", pmval, 0);
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("rate2_pm_256", pmval, 1);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("rate2_am", amval, 2);

        // Fast advance: sweep the AM triangle.
        doReset();
        test = 4'b1000;
        applyStimulus(5, 1'b1, 1'b0);
        checkOutput("fast_pm5", pmval, 5);
        applyStimulus(100, 1'b1, 1'b1);
        checkOutput("apex_dir", am_dir, 0);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("apex_deep", amval, 13);
        am_depth = 1'b1;
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("apex_shallow", amval, 3);
        am_depth = 1'b0;
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("dir_turn_down", am_dir, 1);
        checkOutput("pm_106", pmval, 2);
        applyStimulus(104, 1'b1, 1'b0);
        checkOutput("dir_at_zero", am_dir, 1);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("am_zero", amval, 0);
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("dir_turn_up", am_dir, 0);

        // Coincident CYCLE_00 and CYCLE_21 latch the pre-update count (15 -> 1, not 16 -> 2).
        doReset();
        test = 4'b1000;
        applyStimulus(15, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b1);
        checkOutput("coincident_latch", amval, 1);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("post_coincident", amval, 2);

        // SYNC mid-sweep at cnt=60 going down; SYNC wins over a coincident fast advance.
        doReset();
        test = 4'b1000;
        applyStimulus(150, 1'b1, 1'b0);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("sync_pre_am", amval, 7);
        checkOutput("sync_pre_dir", am_dir, 1);
        checkOutput("sync_pre_pm", pmval, 6);
        sync = 1'b1;
        applyStimulus(1, 1'b1, 1'b0);
        sync = 1'b0;
        checkOutput("sync_pm", pmval, 0);
        checkOutput("sync_dir", am_dir, 0);
        checkOutput("sync_am_held", amval, 7);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("sync_am_relatch", amval, 0);

        // TEST[1] clear with priority over a coincident fast advance.
        applyStimulus(3, 1'b1, 1'b0);
        checkOutput("clr_pre_pm", pmval, 3);
        test = 4'b1010;
        applyStimulus(1, 1'b1, 1'b0);
        test = 4'b1000;
        checkOutput("clr_pm", pmval, 0);
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("clr_resume_pm", pmval, 1);

        // Disabled edges must not advance anything.
        ncen = 1'b1;
        applyStimulus(4, 1'b1, 1'b1);
        ncen = 1'b0;
        checkOutput("gated_pm", pmval, 1);
        checkOutput("gated_am", amval, 0);

        // Async reset between edges with the clock enable inactive.
        applyStimulus(20, 1'b1, 1'b0);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("pre_rst_am", amval, 2);
        checkOutput("pre_rst_pm", pmval, 5);
        @(negedge emuclk);
        ncen = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_pm", pmval, 0);
        checkOutput("async_rst_am", amval, 0);
        checkOutput("async_rst_dir", am_dir, 0);
        @(negedge emuclk);
        rst = 1'b0;
        ncen = 1'b0;
        applyStimulus(5, 1'b1, 1'b0);
        checkOutput("post_rst_pm", pmval, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
